// File: rtl/dcache_line_filler_pkg.sv
// Shared types and helpers for the data-cache line filler.
package dcache_line_filler_pkg;

  localparam int LINE_BEATS = 4;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int LINE_BYTES = 16;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_XFER = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  // Request as latched from the cache at accept time.
  typedef struct packed {
    logic                  rwn;
    logic [15:0]           addr;
    logic [LINE_BYTES-1:0] commit;
    logic [LINE_W-1:0]     wdata;
  } fill_req_t;

  // Word-aligned bus address of word idx within the line holding addr.
  function automatic logic [15:0] beat_addr(input logic [15:0] addr, input logic [1:0] idx);
    return {addr[15:4], idx, 2'b00};
  endfunction

  // Word idx of a 128-bit line.
  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line, input logic [1:0] idx);
    logic [LINE_BEATS-1:0][WORD_W-1:0] w;
    w = line;
    return w[idx];
  endfunction

endpackage

// File: rtl/line_merge.sv
// Byte-mask merge: lane i takes a when m[i] is set, else b.
module line_merge #(
  parameter int NUM_LANES = 16,
  parameter int VEC_W     = 8
) (
  input  logic [NUM_LANES-1:0][VEC_W-1:0] a,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] b,
  input  logic [NUM_LANES-1:0]            m,
  output logic [NUM_LANES-1:0][VEC_W-1:0] y
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign y[i] = m[i] ? a[i] : b[i];
  end

endmodule

// File: rtl/dcache_line_filler.sv
// Line filler: moves one 128-bit line over a 32-bit handshaked bus,
// critical word first, and hands read lines back merged with write-miss bytes.
module dcache_line_filler
  import dcache_line_filler_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  mem_request,
  input  logic                  mem_rwn,
  input  logic [15:0]           mem_addr,
  input  logic [LINE_BYTES-1:0] mem_commit,
  input  logic [LINE_W-1:0]     mem_write_data,
  output logic                  mem_finish,
  output logic                  mem_partial,
  output logic                  mem_replace,
  output logic [4:0]            mem_replace_set,
  output logic [6:0]            mem_replace_tag,
  output logic [LINE_W-1:0]     mem_replace_dat,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [15:0]           bus_addr,
  output logic [WORD_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [WORD_W-1:0]     bus_rdata,
  input  logic                  bus_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  fill_state_e state_q, state_d;
  fill_req_t   req_q, req_d;
  logic [LINE_BEATS-1:0][WORD_W-1:0] buf_q, buf_d;
  logic [1:0]      beat_q, beat_d, idx_q, idx_d, idx_nxt;
  logic [TO_W-1:0] to_q, to_d;

  logic              req_out_d, we_d, finish_d, partial_d, replace_d;
  logic [15:0]       baddr_d;
  logic [WORD_W-1:0] bwdata_d;
  logic [4:0]        set_d;
  logic [6:0]        tag_d;
  logic [LINE_W-1:0] dat_d, mrg_a, mrg_y;
  logic [LINE_BYTES-1:0] mrg_m;
  logic              beat_fail, beat_last;

  assign idx_nxt = idx_q + 2'd1;

  // Error on ack+err, or when this stalled cycle would bring the wait count to TIMEOUT.
  assign beat_fail = bus_ack ? bus_err : (to_q == TO_W'(TIMEOUT - 1));
  assign beat_last = bus_ack && !bus_err && (beat_q == 2'(LINE_BEATS - 1));

  // In IDLE the merge sees the live request so a full-commit read can finish straight away.
  assign mrg_a = (state_q == FILL_IDLE) ? mem_write_data : req_q.wdata;
  assign mrg_m = (state_q == FILL_IDLE) ? mem_commit     : req_q.commit;

  line_merge #(.NUM_LANES(LINE_BYTES), .VEC_W(8)) u_merge (
    .a (mrg_a),
    .b (buf_d),
    .m (mrg_m),
    .y (mrg_y)
  );

  // Line buffer: empty while idle, takes each good read beat into its word slot.
  always_comb begin
    buf_d = buf_q;
    if (state_q == FILL_IDLE)
      buf_d = '0;
    else if (state_q == FILL_XFER && req_q.rwn && bus_ack && !bus_err)
      buf_d[idx_q] = bus_rdata;
  end

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    to_d      = to_q;
    req_out_d = bus_req;
    we_d      = bus_we;
    baddr_d   = bus_addr;
    bwdata_d  = bus_wdata;
    finish_d  = 1'b0;
    partial_d = 1'b0;
    replace_d = 1'b0;
    set_d     = '0;
    tag_d     = '0;
    dat_d     = '0;
    unique case (state_q)
      FILL_IDLE: begin
        if (mem_request) begin
          req_d.rwn    = mem_rwn;
          req_d.addr   = mem_addr;
          req_d.commit = mem_commit;
          req_d.wdata  = mem_write_data;
          beat_d       = '0;
          idx_d        = mem_addr[3:2];
          to_d         = '0;
          if (mem_rwn && (&mem_commit)) begin
            state_d   = FILL_DONE;
            finish_d  = 1'b1;
            replace_d = 1'b1;
            set_d     = mem_addr[8:4];
            tag_d     = mem_addr[15:9];
            dat_d     = mrg_y;
          end else begin
            state_d   = FILL_XFER;
            req_out_d = 1'b1;
            we_d      = ~mem_rwn;
            baddr_d   = beat_addr(mem_addr, mem_addr[3:2]);
            bwdata_d  = mem_rwn ? '0 : word_of(mem_write_data, mem_addr[3:2]);
          end
        end
      end
      FILL_XFER: begin
        if (beat_fail || beat_last) begin
          state_d   = FILL_DONE;
          req_out_d = 1'b0;
          we_d      = 1'b0;
          baddr_d   = '0;
          bwdata_d  = '0;
          finish_d  = 1'b1;
          partial_d = beat_fail;
          replace_d = req_q.rwn;
          if (req_q.rwn) begin
            set_d = req_q.addr[8:4];
            tag_d = req_q.addr[15:9];
            dat_d = mrg_y;
          end
        end else if (bus_ack) begin
          beat_d   = beat_q + 2'd1;
          idx_d    = idx_nxt;
          to_d     = '0;
          baddr_d  = beat_addr(req_q.addr, idx_nxt);
          bwdata_d = req_q.rwn ? '0 : word_of(req_q.wdata, idx_nxt);
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= FILL_IDLE;
    else         state_q <= state_d;
  end

  // Datapath and output registers; reset discards everything in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      req_q           <= '0;
      buf_q           <= '0;
      beat_q          <= '0;
      idx_q           <= '0;
      to_q            <= '0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      mem_finish      <= 1'b0;
      mem_partial     <= 1'b0;
      mem_replace     <= 1'b0;
      mem_replace_set <= '0;
      mem_replace_tag <= '0;
      mem_replace_dat <= '0;
    end else begin
      req_q           <= req_d;
      buf_q           <= buf_d;
      beat_q          <= beat_d;
      idx_q           <= idx_d;
      to_q            <= to_d;
      bus_req         <= req_out_d;
      bus_we          <= we_d;
      bus_addr        <= baddr_d;
      bus_wdata       <= bwdata_d;
      mem_finish      <= finish_d;
      mem_partial     <= partial_d;
      mem_replace     <= replace_d;
      mem_replace_set <= set_d;
      mem_replace_tag <= tag_d;
      mem_replace_dat <= dat_d;
    end
  end

endmodule

// File: tb/tb_dcache_line_filler.sv
// Bench for dcache_line_filler: a bus responder plus a spec-level line model.
module tb_dcache_line_filler;

  localparam int TIMEOUT = 4;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         mem_request, mem_rwn;
  logic [15:0]  mem_addr, mem_commit;
  logic [127:0] mem_write_data;
  logic         mem_finish, mem_partial, mem_replace;
  logic [4:0]   mem_replace_set;
  logic [6:0]   mem_replace_tag;
  logic [127:0] mem_replace_dat;
  logic         bus_req, bus_we;
  logic [15:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_ack, bus_err;
  logic [31:0]  bus_rdata;

  int checks = 0;
  int failures = 0;

  // Responder setup: per-beat stall cycles and memory words by word index.
  int          waits[4];
  logic [31:0] rd_words[4];

  // What the responder saw during one transaction.
  int           obs_n, obs_fin, obs_req_cyc, obs_unstable, obs_proto;
  logic [15:0]  obs_addr[8];
  logic [31:0]  obs_wd[8];
  logic         obs_we[8];
  logic         obs_partial, obs_replace;
  logic [4:0]   obs_set;
  logic [6:0]   obs_tag;
  logic [127:0] obs_dat;

  // What the model predicts.
  int           exp_n, exp_fin;
  logic         exp_partial, exp_replace;
  logic [15:0]  exp_addr[4];
  logic [31:0]  exp_wd[4];
  logic [4:0]   exp_set;
  logic [6:0]   exp_tag;
  logic [127:0] exp_dat;

  dcache_line_filler #(.TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .mem_request(mem_request), .mem_rwn(mem_rwn), .mem_addr(mem_addr),
    .mem_commit(mem_commit), .mem_write_data(mem_write_data),
    .mem_finish(mem_finish), .mem_partial(mem_partial), .mem_replace(mem_replace),
    .mem_replace_set(mem_replace_set), .mem_replace_tag(mem_replace_tag),
    .mem_replace_dat(mem_replace_dat),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [192:0] all_outs();
    return {mem_finish, mem_partial, mem_replace, mem_replace_set, mem_replace_tag,
            mem_replace_dat, bus_req, bus_we, bus_addr, bus_wdata};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Spec model: beat order, latency, partial flag and merged line.
  task automatic model(input logic rwn, input logic [15:0] addr, input logic [15:0] commit,
                       input logic [127:0] wd, input int err_beat, input bit no_ack);
    int a, w, pos, n_ok;
    bit err;
    a   = int'(addr[3:2]);
    err = !no_ack && err_beat >= 0 && err_beat < 4;
    for (int k = 0; k < 4; k++) begin
      w = (a + k) % 4;
      exp_addr[k] = {addr[15:4], 4'(w * 4)};
      exp_wd[k]   = wd[w*32 +: 32];
    end
    if (rwn && commit == 16'hffff) begin
      exp_n = 0; exp_fin = 1; exp_partial = 1'b0; n_ok = 0;
    end else if (no_ack) begin
      exp_n = 1; exp_fin = TIMEOUT + 1; exp_partial = 1'b1; n_ok = 0;
    end else begin
      exp_n = err ? err_beat + 1 : 4;
      n_ok  = err ? err_beat : 4;
      exp_fin = 1;
      for (int k = 0; k < exp_n; k++) exp_fin += 1 + waits[k];
      exp_partial = err;
    end
    exp_replace = rwn;
    exp_set     = rwn ? addr[8:4]  : 5'd0;
    exp_tag     = rwn ? addr[15:9] : 7'd0;
    exp_dat     = '0;
    if (rwn) begin
      for (int b = 0; b < 16; b++) begin
        w   = b / 4;
        pos = (w - a + 4) % 4;
        if (commit[b])     exp_dat[b*8 +: 8] = wd[b*8 +: 8];
        else if (pos < n_ok) exp_dat[b*8 +: 8] = rd_words[w][(b%4)*8 +: 8];
      end
    end
  endtask

  // Cache side holds the request until finish; bus side acks after waits[k] stalls.
  task automatic run_txn(input logic rwn, input logic [15:0] addr, input logic [15:0] commit,
                         input logic [127:0] wd, input int err_beat, input bit no_ack, input bit hold);
    bit pending;
    int wl;
    logic [15:0] ca;
    logic [31:0] cw;
    logic        cwe;
    pending = 0; wl = 0; ca = '0; cw = '0; cwe = 1'b0;
    mem_request = 1'b1; mem_rwn = rwn; mem_addr = addr; mem_commit = commit; mem_write_data = wd;
    obs_n = 0; obs_fin = -1; obs_req_cyc = 0; obs_unstable = 0; obs_proto = 0;
    obs_partial = 1'b0; obs_replace = 1'b0; obs_set = '0; obs_tag = '0; obs_dat = '0;
    for (int cyc = 1; cyc <= 300 && obs_fin < 0; cyc++) begin
      @(negedge sys_clk);
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (mem_replace && !mem_finish) obs_proto++;
      if (mem_finish) begin
        obs_fin = cyc; obs_partial = mem_partial; obs_replace = mem_replace;
        obs_set = mem_replace_set; obs_tag = mem_replace_tag; obs_dat = mem_replace_dat;
        if (bus_req) obs_proto++;
        if (!hold) mem_request = 1'b0;
      end else if (bus_req) begin
        obs_req_cyc++;
        if (!pending) begin
          if (obs_n < 8) begin
            obs_addr[obs_n] = bus_addr; obs_wd[obs_n] = bus_wdata; obs_we[obs_n] = bus_we;
          end
          ca = bus_addr; cw = bus_wdata; cwe = bus_we;
          pending = 1;
          wl = (obs_n < 4) ? waits[obs_n] : 0;
          obs_n++;
        end else if (bus_addr !== ca || bus_wdata !== cw || bus_we !== cwe) begin
          obs_unstable++;
        end
        if (!no_ack && wl == 0) begin
          bus_ack = 1'b1;
          bus_err = (obs_n - 1 == err_beat);
          if (!bus_err) bus_rdata = rd_words[bus_addr[3:2]];
          pending = 0;
        end else begin
          wl--;
        end
      end
    end
    bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; mem_request = 1'b1; mem_rwn = 1'b0; mem_addr = 16'h1238;
    mem_commit = '0; mem_write_data = '1; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    idle(3);
    checks++; if (all_outs() !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs()); end
    mem_request = 1'b0;
    idle(1);
    sys_rst = 1'b0;
    idle(2);
    checks++; if (all_outs() !== '0) begin failures++; $display("FAIL reset_idle got=%h exp=0", all_outs()); end
  endtask

  task automatic test_writeback();
    logic [15:0]  ea[4] = '{16'h1238, 16'h123C, 16'h1230, 16'h1234};
    logic [31:0]  w[4];
    logic [127:0] wd;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    wd = {w[3], w[2], w[1], w[0]};
    waits = '{0, 0, 0, 0};
    run_txn(1'b0, 16'h1238, 16'hffff, wd, -1, 1'b0, 1'b0);
    checks++; if (obs_n !== 4) begin failures++; $display("FAIL wb_beats got=%0d exp=4", obs_n); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (obs_addr[k] !== ea[k] || obs_we[k] !== 1'b1)
        begin failures++; $display("FAIL wb_addr%0d got=%h/%b exp=%h/1", k, obs_addr[k], obs_we[k], ea[k]); end
    end
    checks++; if ({obs_wd[0], obs_wd[1], obs_wd[2], obs_wd[3]} !== {w[2], w[3], w[0], w[1]})
      begin failures++; $display("FAIL wb_wdata got=%h %h %h %h", obs_wd[0], obs_wd[1], obs_wd[2], obs_wd[3]); end
    checks++; if (obs_fin !== 5) begin failures++; $display("FAIL wb_latency got=%0d exp=5", obs_fin); end
    checks++; if ({obs_partial, obs_replace, obs_set, obs_tag, obs_dat} !== '0)
      begin failures++; $display("FAIL wb_replace got=%b%b set=%h tag=%h", obs_partial, obs_replace, obs_set, obs_tag); end
    idle(1);
  endtask

  task automatic test_read_merge();
    logic [15:0]  ea[4] = '{16'hA004, 16'hA008, 16'hA00C, 16'hA000};
    logic [127:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    rd_words = '{32'h44444444, 32'h11111111, 32'h22222222, 32'h33333333};
    waits = '{0, 0, 0, 0};
    run_txn(1'b1, 16'hA004, 16'h00F0, wd, -1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (obs_addr[k] !== ea[k] || obs_we[k] !== 1'b0)
        begin failures++; $display("FAIL rd_addr%0d got=%h/%b exp=%h/0", k, obs_addr[k], obs_we[k], ea[k]); end
    end
    checks++; if (obs_dat !== {32'h33333333, 32'h22222222, wd[63:32], 32'h44444444})
      begin failures++; $display("FAIL rd_merge got=%h", obs_dat); end
    checks++; if ({obs_replace, obs_partial, obs_set, obs_tag} !== {1'b1, 1'b0, 5'h00, 7'h50})
      begin failures++; $display("FAIL rd_fields got=%b%b set=%h tag=%h exp=10 set=00 tag=50", obs_replace, obs_partial, obs_set, obs_tag); end
    checks++; if (obs_fin !== 5 || obs_proto !== 0) begin failures++; $display("FAIL rd_latency got=%0d proto=%0d exp=5", obs_fin, obs_proto); end
    idle(1);
  endtask

  task automatic test_full_commit();
    logic [127:0] wd;
    logic [15:0]  ad;
    wd = {$urandom, $urandom, $urandom, $urandom};
    ad = 16'($urandom);
    run_txn(1'b1, ad, 16'hffff, wd, -1, 1'b0, 1'b0);
    checks++; if (obs_req_cyc !== 0) begin failures++; $display("FAIL fc_bus got=%0d exp=0", obs_req_cyc); end
    checks++; if (obs_fin !== 1) begin failures++; $display("FAIL fc_latency got=%0d exp=1", obs_fin); end
    checks++; if ({obs_replace, obs_partial, obs_dat, obs_set, obs_tag} !== {1'b1, 1'b0, wd, ad[8:4], ad[15:9]})
      begin failures++; $display("FAIL fc_line got=%h exp=%h", obs_dat, wd); end
    idle(1);
  endtask

  task automatic test_error();
    logic [127:0] wd;
    logic [15:0]  ad, cm;
    wd = {$urandom, $urandom, $urandom, $urandom};
    ad = 16'($urandom); cm = 16'($urandom) & 16'h7fff;
    for (int i = 0; i < 4; i++) rd_words[i] = $urandom;
    waits = '{0, 0, 0, 0};
    model(1'b1, ad, cm, wd, 2, 1'b0);
    run_txn(1'b1, ad, cm, wd, 2, 1'b0, 1'b0);
    checks++; if (obs_n !== 3) begin failures++; $display("FAIL err_beats got=%0d exp=3", obs_n); end
    checks++; if (obs_fin !== 4) begin failures++; $display("FAIL err_latency got=%0d exp=4", obs_fin); end
    checks++; if ({obs_replace, obs_partial} !== 2'b11) begin failures++; $display("FAIL err_flags got=%b%b exp=11", obs_replace, obs_partial); end
    checks++; if (obs_dat !== exp_dat) begin failures++; $display("FAIL err_line got=%h exp=%h", obs_dat, exp_dat); end
    idle(1);
  endtask

  task automatic test_timeout();
    logic [127:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    run_txn(1'b0, 16'h4448, 16'h0, wd, -1, 1'b1, 1'b0);
    checks++; if (obs_req_cyc !== TIMEOUT) begin failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", obs_req_cyc, TIMEOUT); end
    checks++; if (obs_fin !== TIMEOUT + 1 || obs_partial !== 1'b1 || obs_replace !== 1'b0)
      begin failures++; $display("FAIL to_finish got=%0d p=%b r=%b exp=%0d p=1 r=0", obs_fin, obs_partial, obs_replace, TIMEOUT + 1); end
    idle(1);
    waits = '{0, 0, 0, 0};
    run_txn(1'b0, 16'h4448, 16'h0, wd, -1, 1'b0, 1'b0);
    checks++; if (obs_fin !== 5 || obs_partial !== 1'b0 || obs_n !== 4)
      begin failures++; $display("FAIL to_recover got=%0d p=%b n=%0d exp=5 p=0 n=4", obs_fin, obs_partial, obs_n); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [127:0] wd, rwd;
    logic [15:0]  ad;
    wd = {$urandom, $urandom, $urandom, $urandom};
    rwd = {$urandom, $urandom, $urandom, $urandom};
    ad = 16'($urandom);
    for (int i = 0; i < 4; i++) rd_words[i] = $urandom;
    waits = '{0, 0, 0, 0};
    run_txn(1'b0, ad, 16'h0, wd, -1, 1'b0, 1'b1);
    checks++; if (obs_fin !== 5) begin failures++; $display("FAIL b2b_wb got=%0d exp=5", obs_fin); end
    model(1'b1, ad, 16'h0F0F, rwd, -1, 1'b0);
    run_txn(1'b1, ad, 16'h0F0F, rwd, -1, 1'b0, 1'b0);
    checks++; if (obs_fin !== exp_fin + 1) begin failures++; $display("FAIL b2b_rd_latency got=%0d exp=%0d", obs_fin, exp_fin + 1); end
    checks++; if (obs_dat !== exp_dat || obs_replace !== 1'b1) begin failures++; $display("FAIL b2b_rd_line got=%h exp=%h", obs_dat, exp_dat); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    mem_request = 1'b1; mem_rwn = 1'b1; mem_addr = 16'h2224; mem_commit = '0; mem_write_data = '0;
    @(negedge sys_clk);
    bus_ack = 1'b1; bus_rdata = $urandom;
    @(negedge sys_clk);
    bus_ack = 1'b0;
    @(negedge sys_clk);
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", bus_req); end
    sys_rst = 1'b1; mem_request = 1'b0;
    @(negedge sys_clk);
    checks++; if (all_outs() !== '0) begin failures++; $display("FAIL rst_mid_outputs got=%h exp=0", all_outs()); end
    sys_rst = 1'b0; bus_ack = 1'b1; bus_rdata = $urandom;
    @(negedge sys_clk);
    bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (all_outs() !== '0) begin failures++; $display("FAIL rst_late_ack got=%h exp=0", all_outs()); end
      @(negedge sys_clk);
    end
    for (int i = 0; i < 4; i++) rd_words[i] = $urandom;
    waits = '{0, 0, 0, 0};
    model(1'b1, 16'h2224, 16'h0, 128'h0, -1, 1'b0);
    run_txn(1'b1, 16'h2224, 16'h0, 128'h0, -1, 1'b0, 1'b0);
    checks++; if (obs_fin !== 5 || obs_dat !== exp_dat) begin failures++; $display("FAIL rst_after got=%0d %h exp=5 %h", obs_fin, obs_dat, exp_dat); end
    idle(1);
  endtask

  task automatic test_random();
    logic         rwn;
    logic [15:0]  ad, cm;
    logic [127:0] wd;
    int           eb, pick;
    bit           na;
    for (int t = 0; t < 40; t++) begin
      rwn = 1'($urandom);
      ad = 16'($urandom);
      cm = ($urandom_range(0, 4) == 0) ? 16'hffff : 16'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      pick = $urandom_range(0, 7);
      eb = (pick < 4) ? pick : -1;
      na = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 4; i++) begin waits[i] = $urandom_range(0, 3); rd_words[i] = $urandom; end
      model(rwn, ad, cm, wd, eb, na);
      run_txn(rwn, ad, cm, wd, eb, na, 1'b0);
      checks++; if (obs_n !== exp_n) begin failures++; $display("FAIL rnd%0d_beats got=%0d exp=%0d", t, obs_n, exp_n); end
      checks++; if (obs_fin !== exp_fin) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, obs_fin, exp_fin); end
      checks++; if ({obs_partial, obs_replace, obs_set, obs_tag} !== {exp_partial, exp_replace, exp_set, exp_tag})
        begin failures++; $display("FAIL rnd%0d_flags got=%b%b %h %h exp=%b%b %h %h", t, obs_partial, obs_replace, obs_set, obs_tag, exp_partial, exp_replace, exp_set, exp_tag); end
      checks++; if (obs_dat !== exp_dat) begin failures++; $display("FAIL rnd%0d_line got=%h exp=%h", t, obs_dat, exp_dat); end
      for (int k = 0; k < exp_n && k < obs_n; k++) begin
        checks++; if (obs_addr[k] !== exp_addr[k] || obs_we[k] !== !rwn || (!rwn && obs_wd[k] !== exp_wd[k]))
          begin failures++; $display("FAIL rnd%0d_beat%0d got=%h/%b/%h exp=%h/%b/%h", t, k, obs_addr[k], obs_we[k], obs_wd[k], exp_addr[k], !rwn, exp_wd[k]); end
      end
      checks++; if (obs_unstable !== 0 || obs_proto !== 0)
        begin failures++; $display("FAIL rnd%0d_handshake unstable=%0d proto=%0d exp=0", t, obs_unstable, obs_proto); end
      idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_read_merge();
    test_full_commit();
    test_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_line_filler.md
# dcache_line_filler

Memory-side engine for the data cache. Accepts the cache's level-held line requests (128-bit write-back or read-allocate), moves the line over a 32-bit single-beat bus in four handshaked beats, and merges write-miss bytes into the fetched line. It returns the line through the cache's replace port, then pulses completion.

## Interface
Parameters:
- TIMEOUT, 255: cycles a beat may wait for `bus_ack` before it is treated as a bus error.

Ports:
- `sys_clk` in 1: clock; all logic rises on posedge.
- `sys_rst` in 1: reset, synchronous, active-high.
- `mem_request` in 1: level; cache holds high until it sees `mem_finish`.
- `mem_rwn` in 1: 1 = read-allocate, 0 = write-back.
- `mem_addr` in 16: byte address; bits [3:0] give the critical offset.
- `mem_commit` in 16: byte mask of write-miss data (reads only).
- `mem_write_data` in 128: write-back line, or write-miss data for a read.
- `mem_finish` out 1: one-cycle completion pulse.
- `mem_partial` out 1: qualifies `mem_finish`/`mem_replace`; 1 = line incomplete due to error.
- `mem_replace` out 1: one-cycle line-write strobe to the cache.
- `mem_replace_set` out 5: set for the replace, = addr[8:4].
- `mem_replace_tag` out 7: tag for the replace, = addr[15:9].
- `mem_replace_dat` out 128: merged line.
- `bus_req` out 1: beat request.
- `bus_we` out 1: beat is a write.
- `bus_addr` out 16: word-aligned beat address.
- `bus_wdata` out 32: write data for the beat.
- `bus_ack` in 1: beat complete.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `bus_err` in 1: error, valid with `bus_ack`.

Every output resets to 0.

## Operation
- **States:** IDLE, XFER, DONE.
- **IDLE to XFER:** when `mem_request`=1, latch `mem_rwn`, `mem_addr`, `mem_commit` and `mem_write_data`, then clear the line buffer, beat count and timeout count.
- **Full-commit read:** a read with `mem_commit`=16'hffff skips the bus. Go to DONE with line = `mem_write_data`.
- **Beat order:** critical word first, wrapping. Beat k uses word index `(addr[3:2]+k) mod 4`. `bus_addr` = {addr[15:4], idx, 2'b00}.
- **Write-back beats:** `bus_wdata` = `mem_write_data[idx*32+:32]`.
- **Read beats:** on `bus_ack`, write `bus_rdata` into buffer word idx.
- **XFER to DONE:** after the 4th acked beat, or on the first error.
- **Error:** `bus_ack && bus_err`, or the timeout counter reaching TIMEOUT. Set the partial flag, abort the remaining beats and drop `bus_req`. Write-back data is lost; the cache is informed through `mem_partial`.
- **Merge (reads):** `mem_replace_dat` byte i = `mem_commit[i]` ? write data byte i : buffer byte i.
- **DONE, one cycle:**
  - `mem_finish`=1, `mem_partial`=flag.
  - For reads, `mem_replace`=1 in the same cycle, with set, tag and dat driven.
  - Then go to IDLE.
- **New request after DONE:** the cycle after DONE, `mem_request` is sampled afresh. The cache reissues a read immediately after a write-back finish; that is accepted normally.
- **Reset in any state:** abort to IDLE, drop `bus_req` at once and discard the buffer. Late `bus_ack` is ignored in IDLE.
- **Write/read field behaviour:**
  - Write-back: `mem_replace`=0 and `mem_commit` is ignored.
  - `mem_replace_*` fields are 0 whenever `mem_replace`=0.

## Timing
- **Outputs:** all registered; no combinational path from bus inputs to any output.
- **Request accept:** IDLE accepts in cycle T. `bus_req` rises at T+1.
- **Beat handshake:**
  - `bus_req`, `bus_addr`, `bus_we` and `bus_wdata` stay stable until the acked cycle.
  - The next beat's `bus_req` stays high in the following cycle with new addr/data, so back-to-back beats run with zero ack latency.
- **Zero-wait latency:** beats at T+1..T+4; DONE (`mem_finish`) at T+5. A full-commit read finishes at T+1.
- **Timeout counter:** counts cycles with `bus_req`=1 and `bus_ack`=0, resetting on each ack. Reaching TIMEOUT has the same effect as `bus_err`; DONE follows the next cycle.
- **Ack plus error:** `bus_ack` with `bus_err` on beat k stores no data. DONE follows the next cycle.
- **Busy:** `mem_request` is ignored outside IDLE.

## Structure
- **In `defines.v`:** state encodings `FILL_IDLE/FILL_XFER/FILL_DONE` and `LINE_BEATS`=4.
- **Sub-module `line_merge`:** combinational 128-bit byte-mask merge, `(A, B, M[15:0]) -> Y`. The cache's write-path merge can reuse it.
- **Datapath registers:** beat counter 2-bit, wrap index 2-bit, timeout counter $clog2(TIMEOUT+1) bits.

## Test plan
- **Write-back, zero-wait:** `mem_rwn`=0, addr 16'h1238, data words W0..W3. Expect:
  - Beats at 0x1238, 0x123C, 0x1230, 0x1234 carrying W2, W3, W0, W1.
  - `mem_finish` at T+5, `mem_partial`=0, `mem_replace`=0.
- **Read with merge:** read of addr 16'hA004, `mem_commit`=16'h00F0, bus returns 0x11111111 through 0x44444444. Expect:
  - Order idx 1, 2, 3, 0.
  - `mem_replace_dat` word 1 = commit data and the others = bus data.
  - set=5'h00, tag=7'h50.
  - `mem_replace` and `mem_finish` in the same cycle.
- **Full commit:** read with `mem_commit`=16'hffff. Expect no `bus_req`; `mem_replace`/`mem_finish` at T+1 with dat = `mem_write_data`.
- **Error on beat 2:** `bus_err` with ack on the 3rd read beat. Expect:
  - No 4th beat.
  - Next cycle `mem_finish`=`mem_replace`=`mem_partial`=1.
- **Timeout:** TIMEOUT=4, no ack. Expect:
  - `bus_req` drops after 4 stalled cycles.
  - `mem_finish`/`mem_partial`=1 next cycle.
  - A subsequent request completes normally.
- **Back-to-back and reset:** write-back then immediate read (request held through finish). Expect:
  - The read is accepted the cycle after DONE.
  - `sys_rst` pulsed mid-beat: all outputs 0 the next cycle, IDLE, a late `bus_ack` is ignored.
